// File: rtl/tick_scheduler.sv
`timescale 1ns/1ps
// Programmable per-channel enable ticks; a tick appears P+2 cycles after the config handshake, its event one cycle later.
// ev_ready low holds the event slot; further ticks queue one deep per channel and set the sticky overrun flag beyond that.
module tick_scheduler #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 26
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic                    sync,
    output logic [N_CH-1:0]         tick,
    output logic                    ev_valid,
    output logic [$clog2(N_CH)-1:0] ev_ch,
    input  logic                    ev_ready,
    output logic [N_CH-1:0]         ovr
);
    localparam int CH_W = $clog2(N_CH);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic {S_IDLE, S_APPLY} state_t;

    state_t            state_q;
    logic              cfg_ready_q;
    logic [CH_W-1:0]   cfg_ch_q;
    logic [CNT_W-1:0]  cfg_period_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cfg_ready_q  <= 1'b0;
            cfg_ch_q     <= '0;
            cfg_period_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_valid && cfg_ready_q) begin
                        cfg_ch_q     <= cfg_ch;
                        cfg_period_q <= cfg_period;
                        cfg_ready_q  <= 1'b0;
                        state_q      <= S_APPLY;
                    end else begin
                        cfg_ready_q  <= 1'b1;
                    end
                end
                S_APPLY: begin
                    cfg_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    cfg_ready_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    logic [CNT_W-1:0] period_q [N_CH];
    logic [CNT_W-1:0] period_d [N_CH];
    logic [CNT_W-1:0] cnt_q    [N_CH];
    logic [CNT_W-1:0] cnt_d    [N_CH];
    logic [N_CH-1:0]  tick_q, tick_d;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  ovr_q, ovr_d;
    logic             ev_valid_q, ev_valid_d;
    logic [CH_W-1:0]  ev_ch_q, ev_ch_d;
    logic [CH_W-1:0]  last_q, last_d;

    logic [N_CH-1:0]  apply, live, wrap, cand, grant;
    logic [CH_W-1:0]  rr_idx [N_CH];
    logic [CH_W-1:0]  pick;
    logic             found, load;

    always_comb begin
        apply = '0;
        live  = '0;
        wrap  = '0;
        tick_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            // Channel numbers beyond N_CH never match, so such writes fall away.
            apply[i]    = (state_q == S_APPLY) && (int'(cfg_ch_q) == i);
            live[i]     = (period_q[i] != '0);
            wrap[i]     = (cnt_q[i] == period_q[i] - ONE);
            tick_d[i]   = live[i] && wrap[i] && !sync && !apply[i];
            period_d[i] = apply[i] ? cfg_period_q : period_q[i];
            cnt_d[i]    = (sync || apply[i] || !live[i] || wrap[i]) ? '0 : cnt_q[i] + ONE;
        end
    end

    // A tick competes for the slot in the cycle it is presented, so an idle slot fills one cycle later.
    always_comb begin
        cand  = pending_q | tick_q;
        load  = !ev_valid_q || ev_ready;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_CH; k++) begin
            rr_idx[k] = CH_W'((int'(last_q) + k + 1) % N_CH);
        end
        for (int k = 0; k < N_CH; k++) begin
            if (!found && cand[rr_idx[k]]) begin
                found = 1'b1;
                pick  = rr_idx[k];
            end
        end
        grant      = '0;
        ev_valid_d = ev_valid_q;
        ev_ch_d    = ev_ch_q;
        last_d     = last_q;
        if (load) begin
            ev_valid_d = found;
            if (found) begin
                ev_ch_d     = pick;
                last_d      = pick;
                grant[pick] = 1'b1;
            end
        end
        pending_d = '0;
        ovr_d     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (apply[i]) begin
                pending_d[i] = 1'b0;
                ovr_d[i]     = 1'b0;
            end else begin
                pending_d[i] = grant[i] ? (pending_q[i] && tick_q[i]) : cand[i];
                ovr_d[i]     = ovr_q[i] || (tick_q[i] && pending_q[i] && !grant[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            tick_q     <= '0;
            pending_q  <= '0;
            ovr_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_ch_q    <= '0;
            last_q     <= CH_W'(N_CH - 1);
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            tick_q     <= tick_d;
            pending_q  <= pending_d;
            ovr_q      <= ovr_d;
            ev_valid_q <= ev_valid_d;
            ev_ch_q    <= ev_ch_d;
            last_q     <= last_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign tick      = tick_q;
    assign ev_valid  = ev_valid_q;
    assign ev_ch     = ev_ch_q;
    assign ovr       = ovr_q;

endmodule
